// File: rtl/counter_burst_sequencer_pkg.sv
// Shared types and default widths for the counter burst sequencer.
package counter_seq_pkg;

    localparam int LEN_W_DEF   = 16;
    localparam int BURST_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/counter_burst_sequencer_seg_timer.sv
// Segment down-counter: loads a length, counts to 1, flags expiry in the last cycle.
module seg_timer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             expire
);

    logic [LEN_W-1:0] cnt;

    // Stops at 0 so an idle timer never wraps into a false expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= len;
        else if (cnt != '0)
            cnt <= cnt - LEN_W'(1);
    end

    assign expire = (cnt == LEN_W'(1));

endmodule

// File: rtl/counter_burst_sequencer.sv
// Drives clear/enable of an enable counter as NUM_BURSTS run/pause bursts.
// Optional endless looping via macro SEQ_LOOP_EN (adds the `loop` input).
module counter_burst_sequencer
    import counter_seq_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
`ifdef SEQ_LOOP_EN
    input  logic               loop,
`endif
    input  logic [LEN_W-1:0]   run_len,
    input  logic [LEN_W-1:0]   pause_len,
    input  logic [BURST_W-1:0] num_bursts,
    output logic               cnt_enable,
    output logic               cnt_reset,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [BURST_W-1:0] burst_idx
);

    seq_state_t         state_q, state_d;
    logic [LEN_W-1:0]   run_len_q, pause_len_q;
    logic [BURST_W-1:0] num_bursts_q, idx_q;
    logic               aborted_q;

    logic               loop_en;
    logic               take_cfg, adv_burst, last_burst;
    logic               tmr_load, tmr_expire;
    logic [LEN_W-1:0]   tmr_len;

`ifdef SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign last_burst = (idx_q == num_bursts_q - BURST_W'(1));

    seg_timer #(.LEN_W(LEN_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        take_cfg  = 1'b0;
        adv_burst = 1'b0;
        tmr_load  = 1'b0;
        tmr_len   = run_len_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = CLEAR;
                    take_cfg = 1'b1;
                end
            end
            CLEAR: begin
                if (num_bursts_q != '0 && run_len_q != '0) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                end else begin
                    state_d  = DONE;
                end
            end
            RUN: begin
                if (tmr_expire) begin
                    if (last_burst && !loop_en) begin
                        state_d = DONE;
                    end else if (pause_len_q == '0) begin
                        // Back-to-back bursts keep enable high without a gap.
                        state_d   = RUN;
                        tmr_load  = 1'b1;
                        adv_burst = 1'b1;
                    end else begin
                        state_d  = PAUSE;
                        tmr_load = 1'b1;
                        tmr_len  = pause_len_q;
                    end
                end
            end
            PAUSE: begin
                if (tmr_expire) begin
                    state_d   = RUN;
                    tmr_load  = 1'b1;
                    adv_burst = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            tmr_load  = 1'b0;
            adv_burst = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            aborted_q    <= 1'b0;
            run_len_q    <= '0;
            pause_len_q  <= '0;
            num_bursts_q <= '0;
            idx_q        <= '0;
        end else begin
            state_q   <= state_d;
            aborted_q <= (state_q != IDLE) && abort;
            if (take_cfg) begin
                run_len_q    <= run_len;
                pause_len_q  <= pause_len;
                num_bursts_q <= num_bursts;
                idx_q        <= '0;
            end else if (adv_burst) begin
                // Advancing past the last burst only happens when looping.
                idx_q <= last_burst ? '0 : idx_q + BURST_W'(1);
            end
        end
    end

    assign cnt_reset  = (state_q == CLEAR);
    assign cnt_enable = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign burst_idx  = idx_q;

endmodule

// File: tb/tb_counter_burst_sequencer.sv
// Self-checking bench for counter_burst_sequencer: directed table, corner sequences, random configs.
module tb_counter_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] run_len, pause_len;
    logic [7:0]  num_bursts;
    logic        cnt_enable, cnt_reset, busy, done, aborted;
    logic [7:0]  burst_idx;
`ifdef SEQ_LOOP_EN
    logic        loop = 1'b0;
`endif

    counter_burst_sequencer #(.LEN_W(16), .BURST_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
`ifdef SEQ_LOOP_EN
        .loop       (loop),
`endif
        .run_len    (run_len),
        .pause_len  (pause_len),
        .num_bursts (num_bursts),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .burst_idx  (burst_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected busy-period waveform, one entry per cycle from the clear cycle to the done cycle.
    typedef struct {
        bit         r;
        bit         e;
        bit         d;
        logic [7:0] idx;
    } cyc_t;
    cyc_t exp_q[$];

    function automatic void build(input int rl, input int pl, input int nb);
        exp_q.delete();
        exp_q.push_back('{r: 1'b1, e: 1'b0, d: 1'b0, idx: 8'd0});
        if (nb != 0 && rl != 0) begin
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < rl; k++) exp_q.push_back('{r: 1'b0, e: 1'b1, d: 1'b0, idx: 8'(b)});
                if (b < nb - 1)
                    for (int k = 0; k < pl; k++) exp_q.push_back('{r: 1'b0, e: 1'b0, d: 1'b0, idx: 8'(b)});
            end
            exp_q.push_back('{r: 1'b0, e: 1'b0, d: 1'b1, idx: 8'(nb - 1)});
        end else begin
            exp_q.push_back('{r: 1'b0, e: 1'b0, d: 1'b1, idx: 8'd0});
        end
    endfunction

    task automatic run_seq(input int rl, input int pl, input int nb, input int abort_at, input bit noise,
                           output int busy_n, output int en_n, output int last_idx);
        build(rl, pl, nb);
        busy_n = 0; en_n = 0; last_idx = 0;
        @(posedge clk); #1;
        run_len = 16'(rl); pause_len = 16'(pl); num_bursts = 8'(nb);
        start = 1'b1; abort = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                run_len = 16'($urandom); pause_len = 16'($urandom); num_bursts = 8'($urandom);
            end
            abort = (i == abort_at);
            @(negedge clk);
            chk("busy", busy, 1);
            chk("cnt_reset", cnt_reset, exp_q[i].r);
            chk("cnt_enable", cnt_enable, exp_q[i].e);
            chk("done", done, exp_q[i].d);
            chk("burst_idx", burst_idx, exp_q[i].idx);
            chk("aborted_low", aborted, 0);
            busy_n += int'(busy);
            en_n   += int'(cnt_enable);
            last_idx = int'(burst_idx);
            if (i == abort_at) begin
                @(posedge clk); #1;
                abort = 1'b0; start = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_en", cnt_enable, 0);
                chk("abort_done", done, 0);
                chk("abort_pulse", aborted, 1);
                @(posedge clk); #1;
                @(negedge clk);
                chk("abort_pulse_end", aborted, 0);
                chk("abort_idle", busy, 0);
                return;
            end
        end
        // Abort while idle must not produce a pulse; burst_idx holds.
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_idx_hold", burst_idx, exp_q[exp_q.size()-1].idx);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_noeffect", aborted, 0);
        chk("idle_busy2", busy, 0);
    endtask

    typedef struct {
        int rl, pl, nb, abort_at;
        bit noise;
        int busy_n, en_n, idx;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int bn, en, li, ab, rl, pl, nb;

        tbl[0] = '{rl: 50, pl: 5, nb: 2, abort_at: -1, noise: 0, busy_n: 107, en_n: 100, idx: 1};
        tbl[1] = '{rl: 5,  pl: 3, nb: 0, abort_at: -1, noise: 0, busy_n: 2,   en_n: 0,   idx: 0};
        tbl[2] = '{rl: 0,  pl: 3, nb: 4, abort_at: -1, noise: 0, busy_n: 2,   en_n: 0,   idx: 0};
        tbl[3] = '{rl: 4,  pl: 0, nb: 3, abort_at: -1, noise: 1, busy_n: 14,  en_n: 12,  idx: 2};
        tbl[4] = '{rl: 1,  pl: 1, nb: 1, abort_at: -1, noise: 0, busy_n: 3,   en_n: 1,   idx: 0};
        tbl[5] = '{rl: 20, pl: 5, nb: 2, abort_at: 10, noise: 0, busy_n: 11,  en_n: 10,  idx: 0};
        tbl[6] = '{rl: 2,  pl: 1, nb: 3, abort_at: -1, noise: 1, busy_n: 10,  en_n: 6,   idx: 2};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        run_len = '0; pause_len = '0; num_bursts = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_en", cnt_enable, 0);
        chk("rst_clr", cnt_reset, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_idx", burst_idx, 0);
        #21 reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_seq(tbl[t].rl, tbl[t].pl, tbl[t].nb, tbl[t].abort_at, tbl[t].noise, bn, en, li);
            chk("tbl_busy_cycles", bn, tbl[t].busy_n);
            chk("tbl_enable_cycles", en, tbl[t].en_n);
            chk("tbl_final_idx", li, tbl[t].idx);
        end

        // start together with abort while idle: stays idle
        @(posedge clk); #1;
        run_len = 16'd3; pause_len = 16'd1; num_bursts = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_clr", cnt_reset, 0);
        chk("start_abort_pulse", aborted, 0);

        // asynchronous reset in the middle of a pause
        @(posedge clk); #1;
        run_len = 16'd3; pause_len = 16'd4; num_bursts = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pause_enable", cnt_enable, 0);
        chk("pause_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_en", cnt_enable, 0);
        chk("async_rst_clr", cnt_reset, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_idx", burst_idx, 0);
        #2 reset = 1'b0;

        // randomized configurations against the waveform model
        for (int n = 0; n < 40; n++) begin
            rl = int'($urandom_range(0, 6));
            pl = int'($urandom_range(0, 4));
            nb = int'($urandom_range(0, 4));
            build(rl, pl, nb);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            run_seq(rl, pl, nb, ab, 1'b1, bn, en, li);
            if (ab < 0) begin
                chk("rand_enable_total", en, nb * rl);
                chk("rand_busy_total", bn, (nb != 0 && rl != 0) ? 2 + nb * rl + (nb - 1) * pl : 2);
            end
        end

`ifdef SEQ_LOOP_EN
        // endless 3-on/2-off loop over two bursts, exited only by abort
        @(posedge clk); #1;
        run_len = 16'd3; pause_len = 16'd2; num_bursts = 8'd2; loop = 1'b1; start = 1'b1;
        for (int j = 0; j < 26; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("loop_busy", busy, 1);
            chk("loop_no_done", done, 0);
            if (j == 0) begin
                chk("loop_clear", cnt_reset, 1);
            end else begin
                chk("loop_clear_once", cnt_reset, 0);
                chk("loop_enable", cnt_enable, ((j - 1) % 5) < 3);
                if (((j - 1) % 5) < 3) chk("loop_idx", burst_idx, ((j - 1) / 5) % 2);
            end
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; loop = 1'b0;
        @(negedge clk);
        chk("loop_abort_pulse", aborted, 1);
        chk("loop_abort_idle", busy, 0);
        chk("loop_abort_en", cnt_enable, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
